// File: rtl/sprite_sched.sv
// sprite_sched: each line, picks the first NUM_ENG vertically visible objects for the sprite engines.
// Optional macro SPRITE_SCHED_STATS_EN adds the per-frame ovf_lines counter output.
module sprite_sched #(
  parameter int CORDW      = 16,
  parameter int NUM_OBJ    = 8,
  parameter int NUM_ENG    = 2,
  parameter int SPR_HEIGHT = 8,
  parameter int SPR_SCALE  = 0,
  parameter int PARK_Y     = -1024,
  localparam int IW = $clog2(NUM_OBJ),
  localparam int CW = $clog2(NUM_ENG + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame,
  input  logic                     sched,
  input  logic signed [CORDW-1:0]  sy_next,
  input  logic                     line,
  input  logic                     wr_en,
  input  logic [IW-1:0]            wr_obj,
  input  logic signed [CORDW-1:0]  wr_x,
  input  logic signed [CORDW-1:0]  wr_y,
  input  logic                     wr_vis,
  output logic [NUM_ENG*CORDW-1:0] eng_x,
  output logic [NUM_ENG*CORDW-1:0] eng_y,
  output logic [NUM_ENG*IW-1:0]    eng_obj,
  output logic [NUM_ENG-1:0]       eng_valid,
  output logic                     overflow,
  output logic                     late,
  output logic                     busy
`ifdef SPRITE_SCHED_STATS_EN
  , output logic [15:0]            ovf_lines
`endif
);

  localparam logic signed [CORDW-1:0] PARK = CORDW'(PARK_Y);
  localparam logic signed [CORDW-1:0] HGT  = CORDW'(SPR_HEIGHT);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_next;

  logic signed [CORDW-1:0] sh_x  [NUM_OBJ];
  logic signed [CORDW-1:0] sh_y  [NUM_OBJ];
  logic [NUM_OBJ-1:0]      sh_vis;
  logic signed [CORDW-1:0] act_x [NUM_OBJ];
  logic signed [CORDW-1:0] act_y [NUM_OBJ];
  logic [NUM_OBJ-1:0]      act_vis;
  logic                    pend, do_commit;

  logic signed [CORDW-1:0] ny;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           count;
  logic signed [CORDW-1:0] wk_x   [NUM_ENG];
  logic signed [CORDW-1:0] wk_y   [NUM_ENG];
  logic [IW-1:0]           wk_obj [NUM_ENG];
  logic [NUM_ENG-1:0]      wk_valid;
  logic                    wk_ovf;

  logic signed [CORDW-1:0] cur_x, cur_y, d;
  logic                    cur_vis, hit, last_obj;

  // A frame arriving outside IDLE waits here; repeats collapse into one commit.
  assign do_commit = (frame | pend) & (state == IDLE);
  assign busy      = (state == SCAN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        sh_x[i]  <= '0;
        sh_y[i]  <= '0;
        act_x[i] <= '0;
        act_y[i] <= '0;
      end
      sh_vis  <= '0;
      act_vis <= '0;
      pend    <= 1'b0;
    end else begin
      pend <= do_commit ? 1'b0 : (pend | frame);
      for (int i = 0; i < NUM_OBJ; i++) begin
        if (wr_en && wr_obj == IW'(i)) begin
          sh_x[i]   <= wr_x;
          sh_y[i]   <= wr_y;
          sh_vis[i] <= wr_vis;
        end
        // Same-cycle write bypasses the shadow so the commit includes it.
        if (do_commit) begin
          if (wr_en && wr_obj == IW'(i)) begin
            act_x[i]   <= wr_x;
            act_y[i]   <= wr_y;
            act_vis[i] <= wr_vis;
          end else begin
            act_x[i]   <= sh_x[i];
            act_y[i]   <= sh_y[i];
            act_vis[i] <= sh_vis[i];
          end
        end
      end
    end
  end

  always_comb begin
    cur_x   = '0;
    cur_y   = '0;
    cur_vis = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      cur_x   = cur_x   | (act_x[i] & {CORDW{idx == IW'(i)}});
      cur_y   = cur_y   | (act_y[i] & {CORDW{idx == IW'(i)}});
      cur_vis = cur_vis | (act_vis[i] & (idx == IW'(i)));
    end
    d        = (ny - cur_y) >>> SPR_SCALE;
    hit      = cur_vis & ~d[CORDW-1] & (d < HGT);
    last_obj = (idx == IW'(NUM_OBJ - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = sched ? SCAN : IDLE;
      SCAN:    state_next = sched ? SCAN : (line ? IDLE : (last_obj ? DONE : SCAN));
      DONE:    state_next = sched ? SCAN : (line ? IDLE : DONE);
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Work slots: cleared by each new scan and by each publish, filled in index order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ny       <= '0;
      idx      <= '0;
      count    <= '0;
      wk_valid <= '0;
      wk_ovf   <= 1'b0;
      for (int k = 0; k < NUM_ENG; k++) begin
        wk_x[k]   <= '0;
        wk_y[k]   <= '0;
        wk_obj[k] <= '0;
      end
    end else if (sched) begin
      ny       <= sy_next;
      idx      <= '0;
      count    <= '0;
      wk_valid <= '0;
      wk_ovf   <= 1'b0;
    end else if (line) begin
      idx      <= '0;
      count    <= '0;
      wk_valid <= '0;
      wk_ovf   <= 1'b0;
    end else if (state == SCAN) begin
      idx <= last_obj ? '0 : idx + 1'b1;
      if (hit) begin
        for (int k = 0; k < NUM_ENG; k++) begin
          if (count == CW'(k)) begin
            wk_x[k]     <= cur_x;
            wk_y[k]     <= cur_y;
            wk_obj[k]   <= idx;
            wk_valid[k] <= 1'b1;
          end
        end
        if (count == CW'(NUM_ENG)) wk_ovf <= 1'b1;
        else                       count  <= count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_ENG; k++) begin
        eng_x[k*CORDW +: CORDW] <= '0;
        eng_y[k*CORDW +: CORDW] <= PARK;
        eng_obj[k*IW +: IW]     <= '0;
      end
      eng_valid <= '0;
      overflow  <= 1'b0;
      late      <= 1'b0;
    end else if (line) begin
      for (int k = 0; k < NUM_ENG; k++) begin
        eng_x[k*CORDW +: CORDW] <= wk_valid[k] ? wk_x[k] : '0;
        eng_y[k*CORDW +: CORDW] <= wk_valid[k] ? wk_y[k] : PARK;
        eng_obj[k*IW +: IW]     <= wk_valid[k] ? wk_obj[k] : '0;
      end
      eng_valid <= wk_valid;
      overflow  <= wk_ovf;
      late      <= (state == SCAN);
    end
  end

`ifdef SPRITE_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            ovf_lines <= 16'd0;
    else if (frame)                                     ovf_lines <= (line && wk_ovf) ? 16'd1 : 16'd0;
    else if (line && wk_ovf && ovf_lines != 16'hFFFF)   ovf_lines <= ovf_lines + 16'd1;
  end
`endif

endmodule
